// File: rtl/snn_pkg.sv
// Shared types and defaults for the tiny SNN frame scheduler slice.
package snn_pkg;

   localparam int unsigned P_N_DEF  = 8;
   localparam int unsigned P_CW_DEF = 8;
   localparam int unsigned P_IW     = $clog2(P_N_DEF);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRun    = 2'd1,
      StDrain  = 2'd2,
      StReport = 2'd3
   } state_e;

endpackage

// File: rtl/snn_frame_scheduler_if.sv
// Control inputs and latched frame results of the SNN frame scheduler.
interface snn_frame_scheduler_if
   import snn_pkg::*;
#(
   parameter int unsigned P_N  = P_N_DEF,
   parameter int unsigned P_CW = P_CW_DEF
) ();

   logic                  i_start;
   logic                  i_auto;
   logic                  i_abort;
   logic [P_N-1:0]        i_spike;
   logic                  o_busy;
   logic                  o_net_clr;
   logic                  o_frame_done;
   logic [P_N*P_CW-1:0]   o_spike_cnt;
   logic [P_IW-1:0]       o_winner;
   logic                  o_winner_vld;
   logic [7:0]            o_frame_id;

   modport master (
      output i_start, i_auto, i_abort, i_spike,
      input  o_busy, o_net_clr, o_frame_done, o_spike_cnt, o_winner, o_winner_vld, o_frame_id
   );

   modport slave (
      input  i_start, i_auto, i_abort, i_spike,
      output o_busy, o_net_clr, o_frame_done, o_spike_cnt, o_winner, o_winner_vld, o_frame_id
   );

endinterface

// File: rtl/snn_argmax.sv
// Combinational arg-max over packed per-neuron counts; ties resolve to the lowest index.
module snn_argmax
   import snn_pkg::*;
#(
   parameter int unsigned P_N  = P_N_DEF,
   parameter int unsigned P_CW = P_CW_DEF
) (
   input  logic [P_N*P_CW-1:0] counts,
   output logic [P_IW-1:0]     idx,
   output logic                nonzero
);

   logic [P_CW-1:0] best;

   always_comb begin
      best = counts[P_CW-1:0];
      idx  = '0;
      // strict greater-than keeps the earliest index on a tie
      for (int i = 1; i < int'(P_N); i++) begin
         if (counts[i*P_CW +: P_CW] > best) begin
            best = counts[i*P_CW +: P_CW];
            idx  = P_IW'(i);
         end
      end
      nonzero = (best != '0);
   end

endmodule

// File: rtl/snn_frame_scheduler.sv
// Event-clocked frame controller: counts output spikes per neuron over a frame plus drain window.
module snn_frame_scheduler
   import snn_pkg::*;
#(
   parameter int unsigned P_N         = P_N_DEF,
   parameter int unsigned P_FRAME_LEN = 200,
   parameter int unsigned P_DRAIN     = 4,
   parameter int unsigned P_CW        = P_CW_DEF
) (
   input  logic                 w_cnt_clk,
   input  logic                 r_rst_n,
   snn_frame_scheduler_if.slave bus
);

   localparam logic [7:0] LastEv = 8'(P_FRAME_LEN - 1);
   localparam logic [3:0] LastDr = 4'(P_DRAIN - 1);

   state_e                    state_q;
   logic [7:0]                ev_cnt_q;
   logic [3:0]                dr_cnt_q;
   logic [P_N-1:0][P_CW-1:0]  acc_q;
   logic                      busy_q;
   logic                      net_clr_q;
   logic                      frame_done_q;
   logic [P_N*P_CW-1:0]       spike_cnt_q;
   logic [P_IW-1:0]           winner_q;
   logic                      winner_vld_q;
   logic [7:0]                frame_id_q;

   logic [P_IW-1:0]           am_idx;
   logic                      am_nz;

   snn_argmax #(
      .P_N  (P_N),
      .P_CW (P_CW)
   ) u_argmax (
      .counts  (acc_q),
      .idx     (am_idx),
      .nonzero (am_nz)
   );

   always_ff @(posedge w_cnt_clk or negedge r_rst_n) begin
      if (!r_rst_n) begin
         state_q      <= StIdle;
         ev_cnt_q     <= '0;
         dr_cnt_q     <= '0;
         acc_q        <= '0;
         busy_q       <= 1'b0;
         net_clr_q    <= 1'b0;
         frame_done_q <= 1'b0;
         spike_cnt_q  <= '0;
         winner_q     <= '0;
         winner_vld_q <= 1'b0;
         frame_id_q   <= '0;
      end else begin
         net_clr_q    <= 1'b0;
         frame_done_q <= 1'b0;
         if (bus.i_abort && (state_q != StIdle)) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            busy_q    <= 1'b0;
            net_clr_q <= 1'b1;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (bus.i_start) begin
                     state_q   <= StRun;
                     ev_cnt_q  <= '0;
                     acc_q     <= '0;
                     busy_q    <= 1'b1;
                     net_clr_q <= 1'b1;
                  end
               end
               StRun, StDrain: begin
                  for (int k = 0; k < int'(P_N); k++) begin
                     if (bus.i_spike[k] && (acc_q[k] != '1)) begin
                        acc_q[k] <= acc_q[k] + P_CW'(1);
                     end
                  end
                  if (state_q == StRun) begin
                     ev_cnt_q <= ev_cnt_q + 8'd1;
                     if (ev_cnt_q == LastEv) begin
                        state_q  <= StDrain;
                        dr_cnt_q <= '0;
                     end
                  end else begin
                     dr_cnt_q <= dr_cnt_q + 4'd1;
                     if (dr_cnt_q == LastDr) begin
                        state_q <= StReport;
                     end
                  end
               end
               StReport: begin
                  spike_cnt_q  <= acc_q;
                  winner_q     <= am_idx;
                  winner_vld_q <= am_nz;
                  frame_done_q <= 1'b1;
                  net_clr_q    <= 1'b1;
                  frame_id_q   <= frame_id_q + 8'd1;
                  if (bus.i_auto) begin
                     state_q  <= StRun;
                     ev_cnt_q <= '0;
                     acc_q    <= '0;
                     busy_q   <= 1'b1;
                  end else begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign bus.o_busy       = busy_q;
   assign bus.o_net_clr    = net_clr_q;
   assign bus.o_frame_done = frame_done_q;
   assign bus.o_spike_cnt  = spike_cnt_q;
   assign bus.o_winner     = winner_q;
   assign bus.o_winner_vld = winner_vld_q;
   assign bus.o_frame_id   = frame_id_q;

endmodule

// File: doc/snn_frame_scheduler.md
Name: snn_frame_scheduler

Overview:
Frame-level controller for the 8-neuron tiny SNN network. Clocked by the input-event strobe, so one clock edge equals one input event. It divides the event stream into fixed-length frames and counts output spikes per neuron in each frame. At each frame boundary it issues the network clear, publishes per-neuron rates and the winning neuron, and then restarts or idles.

Parameters:
P_N, 8, number of output neurons
P_FRAME_LEN, 200, input events per frame (RUN phase length), range 2..255
P_DRAIN, 4, extra events counted after the frame to absorb network latency, range 1..15
P_CW, 8, width of each per-neuron spike counter

Ports:
w_cnt_clk  in  1  clock: one rising edge per input event; the only clock
r_rst_n  in  1  reset, asynchronous, active-low
i_start  in  1  begin a frame; sampled on w_cnt_clk
i_auto  in  1  1 = start the next frame immediately after REPORT
i_abort  in  1  abandon the current frame; highest priority
i_spike  in  P_N  network output spikes, bit n-1 = neuron n, sampled on w_cnt_clk
o_busy  out  1  high in RUN, DRAIN, REPORT
o_net_clr  out  1  one-edge pulse: clear network membrane state
o_frame_done  out  1  one-edge pulse: results valid from this edge on
o_spike_cnt  out  P_N*P_CW  latched per-neuron counts; neuron n at bits [n*P_CW-1:(n-1)*P_CW]
o_winner  out  3  index 0..7 of the neuron with the highest latched count
o_winner_vld  out  1  latched max count > 0
o_frame_id  out  8  completed-frame counter

Behaviour:
- Reset (async, r_rst_n=0): state IDLE. All outputs 0. Internal counters 0.
- States: IDLE, RUN, DRAIN, REPORT. All transitions happen on rising edges of w_cnt_clk.
- IDLE, i_start=1:
  - go to RUN
  - clear accumulators and ev_cnt
  - o_net_clr=1 for that edge only
  - the spike on this edge is not counted
- RUN:
  - each edge: ev_cnt++
  - each edge: acc[n] += i_spike[n-1], saturating at 2^P_CW-1
  - when ev_cnt==P_FRAME_LEN-1 on an edge (that edge counted): go to DRAIN, dr_cnt=0
  - exactly P_FRAME_LEN edges are counted in RUN
- DRAIN:
  - accumulate spikes as in RUN; dr_cnt++ each edge
  - on the edge with dr_cnt==P_DRAIN-1: go to REPORT
- REPORT (one edge):
  - o_spike_cnt <= acc; winner logic latches o_winner and o_winner_vld
  - o_frame_done=1 and o_net_clr=1 for this edge
  - o_frame_id++, wrapping 255->0
  - the spike on this edge is not counted
  - next state: RUN (accumulators cleared) if i_auto=1, else IDLE
  - i_start in REPORT is ignored
- Winner logic:
  - largest acc wins
  - ties go to the lowest index
  - all zero: o_winner=0, o_winner_vld=0
- Latched outputs hold until the next REPORT or reset.
- o_net_clr and o_frame_done are single-edge pulses: 0 on the next edge unless re-asserted.
- i_abort=1 in any non-IDLE state:
  - next state IDLE; accumulators cleared
  - o_net_clr=1 for one edge
  - o_spike_cnt, o_winner and o_frame_id are unchanged; o_frame_done stays 0
- i_abort takes priority over i_start and i_auto on the same edge. In IDLE, i_abort is ignored.
- o_busy is registered and equals (state != IDLE).
- Because the clock is event-driven, nothing advances without events. Verification checks ordering per edge, not wall time.

Decomposition:
- Shared package snn_pkg holds:
  - state encoding (2-bit enum: IDLE=0, RUN=1, DRAIN=2, REPORT=3)
  - P_N, P_CW defaults
  - the neuron-index width constant
- One sub-module, snn_argmax:
  - combinational max over P_N counts
  - lowest-index tie-break
  - outputs index and nonzero flag
  - instantiated once

Test Plan:
1. Reset, then i_start=1 with P_FRAME_LEN=200, P_DRAIN=4, neuron 3 spiking every 2nd event -> o_frame_done on the 206th edge after start; count[3]=102; o_winner=2; o_winner_vld=1; o_frame_id=1.
2. No spikes for a whole frame -> all counts 0, o_winner=0, o_winner_vld=0, o_frame_done still pulses.
3. Neurons 5 and 2 both with 50 spikes -> o_winner=1 (lowest index on tie).
4. Neuron 1 spiking every edge with P_FRAME_LEN=255, P_DRAIN=15 -> count[1]=255 (saturated, no wrap).
5. i_auto=1 over 3 frames -> REPORT goes straight to RUN; o_frame_id counts 1,2,3; o_net_clr pulses once per frame.
6. i_abort at event 100 of frame 2 -> IDLE next edge, o_net_clr pulses, frame-1 results and o_frame_id=1 retained. Async reset mid-DRAIN -> all outputs 0 immediately.
